mem_wb_writeback: RTL and testbench

MEM/WB pipeline register and writeback stage of the pipelined datapath; it drives the write port of `nbit_register_file`. It latches the MEM-stage result on each clock edge and selects ALU, load or link data. It generates `RegWrite`/`write_address`/`write_data` and suppresses writes to register 0. It also flags same-cycle ID reads that must bypass the register file, and counts retired instructions.

---
 rtl/datapath_pkg.sv | 19 +
 rtl/mem_wb_writeback_if.sv | 42 ++++
 rtl/mem_wb_writeback_reg.sv | 86 ++++++++
 rtl/mem_wb_writeback.sv | 88 ++++++++
 tb/tb_mem_wb_writeback.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: writeback-select encodings and default widths.
package datapath_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int SELECT_WIDTH_DEF = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_LINK = 2'b10,
      WB_RSVD = 2'b11
   } wb_sel_e;

   // The reserved select still drives ALU data but never commits a write.
   function automatic logic wb_sel_writes(input wb_sel_e sel);
      return sel != WB_RSVD;
   endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// Bundle between the MEM stage / ID stage and the writeback block.
interface mem_wb_writeback_if
   import datapath_pkg::*;
#(
   parameter int data_width   = DATA_WIDTH_DEF,
   parameter int select_width = SELECT_WIDTH_DEF
);
   logic                    stall;
   logic                    flush;
   logic                    mem_valid;
   logic                    mem_reg_write;
   logic [1:0]              mem_wb_sel;
   logic [data_width-1:0]   mem_alu_result;
   logic [data_width-1:0]   mem_load_data;
   logic [data_width-1:0]   mem_pc_plus4;
   logic [select_width-1:0] mem_dest;
   logic [select_width-1:0] id_rs;
   logic [select_width-1:0] id_rt;
   logic                    RegWrite;
   logic [select_width-1:0] write_address;
   logic [data_width-1:0]   write_data;
   logic                    fwd_rs;
   logic                    fwd_rt;
   logic [31:0]             retired_count;

   modport master (
      output stall, flush, mem_valid, mem_reg_write, mem_wb_sel,
             mem_alu_result, mem_load_data, mem_pc_plus4, mem_dest,
             id_rs, id_rt,
      input  RegWrite, write_address, write_data, fwd_rs, fwd_rt,
             retired_count
   );

   modport slave (
      input  stall, flush, mem_valid, mem_reg_write, mem_wb_sel,
             mem_alu_result, mem_load_data, mem_pc_plus4, mem_dest,
             id_rs, id_rt,
      output RegWrite, write_address, write_data, fwd_rs, fwd_rt,
             retired_count
   );

endinterface

// File: rtl/mem_wb_writeback_reg.sv
// MEM/WB pipeline register: flush beats stall, stall beats load.
module mem_wb_reg
   import datapath_pkg::*;
#(
   parameter int data_width   = DATA_WIDTH_DEF,
   parameter int select_width = SELECT_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic                    mem_valid_i,
   input  logic                    mem_reg_write_i,
   input  logic [1:0]              mem_wb_sel_i,
   input  logic [data_width-1:0]   mem_alu_i,
   input  logic [data_width-1:0]   mem_load_i,
   input  logic [data_width-1:0]   mem_link_i,
   input  logic [select_width-1:0] mem_dest_i,
   output logic                    wb_valid_o,
   output logic                    wb_reg_write_o,
   output wb_sel_e                 wb_sel_o,
   output logic [data_width-1:0]   wb_alu_o,
   output logic [data_width-1:0]   wb_load_o,
   output logic [data_width-1:0]   wb_link_o,
   output logic [select_width-1:0] wb_dest_o
);

   logic                    valid_q,     valid_d;
   logic                    reg_write_q, reg_write_d;
   wb_sel_e                 sel_q,       sel_d;
   logic [data_width-1:0]   alu_q,       alu_d;
   logic [data_width-1:0]   load_q,      load_d;
   logic [data_width-1:0]   link_q,      link_d;
   logic [select_width-1:0] dest_q,      dest_d;

   // A flush only kills the valid bit; the data fields keep their old contents.
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      sel_d       = sel_q;
      alu_d       = alu_q;
      load_d      = load_q;
      link_d      = link_q;
      dest_d      = dest_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (!stall_i) begin
         valid_d     = mem_valid_i;
         reg_write_d = mem_reg_write_i;
         sel_d       = wb_sel_e'(mem_wb_sel_i);
         alu_d       = mem_alu_i;
         load_d      = mem_load_i;
         link_d      = mem_link_i;
         dest_d      = mem_dest_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         sel_q       <= WB_ALU;
         alu_q       <= '0;
         load_q      <= '0;
         link_q      <= '0;
         dest_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         sel_q       <= sel_d;
         alu_q       <= alu_d;
         load_q      <= load_d;
         link_q      <= link_d;
         dest_q      <= dest_d;
      end
   end

   assign wb_valid_o     = valid_q;
   assign wb_reg_write_o = reg_write_q;
   assign wb_sel_o       = sel_q;
   assign wb_alu_o       = alu_q;
   assign wb_load_o      = load_q;
   assign wb_link_o      = link_q;
   assign wb_dest_o      = dest_q;

endmodule

// File: rtl/mem_wb_writeback.sv
// Writeback stage: MEM/WB register, data select, write qualification,
// same-cycle ID bypass detection and retired-instruction counter.
module mem_wb_writeback
   import datapath_pkg::*;
#(
   parameter int data_width   = DATA_WIDTH_DEF,
   parameter int select_width = SELECT_WIDTH_DEF
) (
   input logic         clk,
   input logic         rst_n,
   mem_wb_writeback_if.slave bus
);

   logic                    wb_valid;
   logic                    wb_reg_write;
   wb_sel_e                 wb_sel;
   logic [data_width-1:0]   wb_alu;
   logic [data_width-1:0]   wb_load;
   logic [data_width-1:0]   wb_link;
   logic [select_width-1:0] wb_dest;

   logic                    reg_write;
   logic [data_width-1:0]   write_data;
   logic                    retire;
   logic [31:0]             retired_q, retired_d;

   mem_wb_reg #(
      .data_width   (data_width),
      .select_width (select_width)
   ) u_mem_wb_reg (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (bus.stall),
      .flush_i         (bus.flush),
      .mem_valid_i     (bus.mem_valid),
      .mem_reg_write_i (bus.mem_reg_write),
      .mem_wb_sel_i    (bus.mem_wb_sel),
      .mem_alu_i       (bus.mem_alu_result),
      .mem_load_i      (bus.mem_load_data),
      .mem_link_i      (bus.mem_pc_plus4),
      .mem_dest_i      (bus.mem_dest),
      .wb_valid_o      (wb_valid),
      .wb_reg_write_o  (wb_reg_write),
      .wb_sel_o        (wb_sel),
      .wb_alu_o        (wb_alu),
      .wb_load_o       (wb_load),
      .wb_link_o       (wb_link),
      .wb_dest_o       (wb_dest)
   );

   always_comb begin
      write_data = wb_alu;
      case (wb_sel)
         WB_LOAD: write_data = wb_load;
         WB_LINK: write_data = wb_link;
         default: write_data = wb_alu;
      endcase
   end

   // r0 is hardwired zero, so gating on dest != 0 also keeps r0 reads from forwarding.
   assign reg_write = wb_valid & wb_reg_write & wb_sel_writes(wb_sel) &
                      (wb_dest != '0);

   assign retire = wb_valid & ~bus.stall & ~bus.flush;

   always_comb begin
      retired_d = retired_q;
      if (retire) begin
         retired_d = retired_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign bus.RegWrite      = reg_write;
   assign bus.write_address = wb_dest;
   assign bus.write_data    = write_data;
   assign bus.fwd_rs        = reg_write & (bus.id_rs == wb_dest);
   assign bus.fwd_rt        = reg_write & (bus.id_rt == wb_dest);
   assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vector table, hand-written reset/wrap
// sequences, then random traffic against a slot-level reference model.
module tb_mem_wb_writeback;

   logic clk;
   logic rst_n;

   mem_wb_writeback_if #(.data_width(32), .select_width(5)) bus ();

   mem_wb_writeback #(.data_width(32), .select_width(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in register file fed from the write port.
   logic [31:0] rf [32];
   always @(posedge clk) begin
      if (bus.RegWrite) rf[bus.write_address] <= bus.write_data;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall, flush, valid, rw;
      logic [1:0]  sel;
      logic [31:0] alu, load, link;
      logic [4:0]  dest, rs, rt;
      logic        e_rw, e_chk_data;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_frs, e_frt;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs [16];

   task automatic drive(input logic stall, input logic flush, input logic valid,
                        input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] load, input logic [31:0] link,
                        input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
      bus.stall          = stall;
      bus.flush          = flush;
      bus.mem_valid      = valid;
      bus.mem_reg_write  = rw;
      bus.mem_wb_sel     = sel;
      bus.mem_alu_result = alu;
      bus.mem_load_data  = load;
      bus.mem_pc_plus4   = link;
      bus.mem_dest       = dest;
      bus.id_rs          = rs;
      bus.id_rt          = rt;
   endtask

   // Reference model: one WB slot described by what the instruction is.
   typedef struct {
      logic        valid, rw;
      logic [1:0]  sel;
      logic [31:0] alu, load, link;
      logic [4:0]  dest;
      logic        known;
   } slot_t;

   slot_t       m_slot;
   logic [31:0] m_cnt;

   function automatic logic m_writes(input slot_t s);
      return s.valid && s.rw && (s.sel != 2'd3) && (s.dest != 5'd0);
   endfunction

   function automatic logic [31:0] m_data(input slot_t s);
      if (s.sel == 2'd1) return s.load;
      if (s.sel == 2'd2) return s.link;
      return s.alu;
   endfunction

   initial begin
      logic stall, flush;
      logic wexp;

      vecs[0]  = '{0,0,1,1,2'd0,32'h1234,32'h0,32'h0,5'd5,5'd5,5'd3,      1,1,5'd5,32'h1234,1,0,32'd0};
      vecs[1]  = '{0,0,1,1,2'd1,32'h1111,32'hDEADBEEF,32'h0,5'd8,5'd0,5'd8, 1,1,5'd8,32'hDEADBEEF,0,1,32'd1};
      vecs[2]  = '{0,0,1,1,2'd2,32'h0,32'h0,32'h40,5'd31,5'd31,5'd31,     1,1,5'd31,32'h40,1,1,32'd2};
      vecs[3]  = '{0,0,1,1,2'd0,32'h55,32'h0,32'h0,5'd0,5'd0,5'd0,        0,1,5'd0,32'h55,0,0,32'd3};
      vecs[4]  = '{0,0,1,1,2'd3,32'h77,32'h0,32'h0,5'd9,5'd9,5'd0,        0,1,5'd9,32'h77,0,0,32'd4};
      vecs[5]  = '{0,0,0,1,2'd0,32'h99,32'h0,32'h0,5'd4,5'd4,5'd0,        0,1,5'd4,32'h99,0,0,32'd5};
      vecs[6]  = '{0,0,1,0,2'd0,32'hAB,32'h0,32'h0,5'd6,5'd6,5'd0,        0,1,5'd6,32'hAB,0,0,32'd5};
      vecs[7]  = '{0,0,1,1,2'd0,32'h700,32'h0,32'h0,5'd7,5'd7,5'd3,       1,1,5'd7,32'h700,1,0,32'd6};
      vecs[8]  = '{1,0,1,1,2'd0,32'hA,32'h0,32'h0,5'd10,5'd7,5'd3,        1,1,5'd7,32'h700,1,0,32'd6};
      vecs[9]  = '{1,0,1,1,2'd0,32'hA,32'h0,32'h0,5'd10,5'd7,5'd3,        1,1,5'd7,32'h700,1,0,32'd6};
      vecs[10] = '{1,0,1,1,2'd0,32'hA,32'h0,32'h0,5'd10,5'd7,5'd3,        1,1,5'd7,32'h700,1,0,32'd6};
      vecs[11] = '{0,0,1,1,2'd0,32'hA,32'h0,32'h0,5'd10,5'd7,5'd3,        1,1,5'd10,32'hA,0,0,32'd7};
      vecs[12] = '{1,1,1,1,2'd0,32'hC,32'h0,32'h0,5'd12,5'd10,5'd0,       0,0,5'd0,32'h0,0,0,32'd7};
      vecs[13] = '{0,0,1,1,2'd0,32'hD,32'h0,32'h0,5'd13,5'd13,5'd0,       1,1,5'd13,32'hD,1,0,32'd7};
      vecs[14] = '{0,1,1,1,2'd0,32'hE,32'h0,32'h0,5'd14,5'd13,5'd0,       0,0,5'd0,32'h0,0,0,32'd7};
      vecs[15] = '{0,0,0,0,2'd0,32'hF,32'h0,32'h0,5'd15,5'd0,5'd0,        0,1,5'd15,32'hF,0,0,32'd7};

      // Reset state
      rst_n = 1'b0;
      drive(0,0,0,0,2'd0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0);
      #2;
      chk("reset_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      chk("reset_addr",     {27'd0, bus.write_address}, 32'd0);
      chk("reset_data",     bus.write_data, 32'd0);
      chk("reset_fwd",      {30'd0, bus.fwd_rs, bus.fwd_rt}, 32'd0);
      chk("reset_count",    bus.retired_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].sel,
               vecs[i].alu, vecs[i].load, vecs[i].link, vecs[i].dest, vecs[i].rs, vecs[i].rt);
         @(posedge clk);
         #1;
         $display("vec %0d: stall=%0b flush=%0b RegWrite=%0b addr=%0d data=%08h fwd=%0b%0b count=%0d",
                  i, vecs[i].stall, vecs[i].flush, bus.RegWrite, bus.write_address,
                  bus.write_data, bus.fwd_rs, bus.fwd_rt, bus.retired_count);
         chk($sformatf("vec%0d_regwrite", i), {31'd0, bus.RegWrite}, {31'd0, vecs[i].e_rw});
         chk($sformatf("vec%0d_fwd_rs", i),   {31'd0, bus.fwd_rs},   {31'd0, vecs[i].e_frs});
         chk($sformatf("vec%0d_fwd_rt", i),   {31'd0, bus.fwd_rt},   {31'd0, vecs[i].e_frt});
         chk($sformatf("vec%0d_count", i),    bus.retired_count, vecs[i].e_cnt);
         if (vecs[i].e_chk_data) begin
            chk($sformatf("vec%0d_addr", i), {27'd0, bus.write_address}, {27'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_data", i), bus.write_data, vecs[i].e_data);
         end
         if (i == 1) chk("rf_r5_after_commit", rf[5], 32'h1234);
      end

      // Asynchronous reset mid-cycle while stall and flush are high
      @(negedge clk);
      drive(0,0,1,1,2'd0,32'h5A5A,32'h0,32'h0,5'd5,5'd5,5'd0);
      @(posedge clk);
      #1;
      chk("prerst_regwrite", {31'd0, bus.RegWrite}, 32'd1);
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: RegWrite=%0b addr=%0d data=%08h fwd=%0b%0b count=%0d",
               bus.RegWrite, bus.write_address, bus.write_data, bus.fwd_rs, bus.fwd_rt,
               bus.retired_count);
      chk("asyncrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      chk("asyncrst_addr",     {27'd0, bus.write_address}, 32'd0);
      chk("asyncrst_data",     bus.write_data, 32'd0);
      chk("asyncrst_fwd_rs",   {31'd0, bus.fwd_rs}, 32'd0);
      chk("asyncrst_count",    bus.retired_count, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0,0,1,1,2'd0,32'h33,32'h0,32'h0,5'd3,5'd3,5'd1);
      @(posedge clk);
      #1;
      $display("post reset load: RegWrite=%0b addr=%0d data=%08h count=%0d",
               bus.RegWrite, bus.write_address, bus.write_data, bus.retired_count);
      chk("postrst_regwrite", {31'd0, bus.RegWrite}, 32'd1);
      chk("postrst_addr",     {27'd0, bus.write_address}, 32'd3);
      chk("postrst_data",     bus.write_data, 32'h33);
      chk("postrst_fwd_rs",   {31'd0, bus.fwd_rs}, 32'd1);
      chk("postrst_count",    bus.retired_count, 32'd0);

      // Random traffic against the reference model
      m_slot = '{valid:1'b1, rw:1'b1, sel:2'd0, alu:32'h33, load:32'h0, link:32'h0,
                 dest:5'd3, known:1'b1};
      m_cnt  = 32'd0;
      for (int c = 0; c < 250; c++) begin
         @(negedge clk);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         drive(stall, flush, ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0),
               2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         @(posedge clk);
         if (m_slot.valid && !stall && !flush) m_cnt = m_cnt + 32'd1;
         if (flush) begin
            m_slot.valid = 1'b0;
            m_slot.known = 1'b0;
         end else if (!stall) begin
            m_slot = '{valid:bus.mem_valid, rw:bus.mem_reg_write, sel:bus.mem_wb_sel,
                       alu:bus.mem_alu_result, load:bus.mem_load_data,
                       link:bus.mem_pc_plus4, dest:bus.mem_dest, known:1'b1};
         end
         #1;
         wexp = m_writes(m_slot);
         $display("rnd %0d: stall=%0b flush=%0b RegWrite=%0b addr=%0d data=%08h fwd=%0b%0b count=%0d",
                  c, stall, flush, bus.RegWrite, bus.write_address, bus.write_data,
                  bus.fwd_rs, bus.fwd_rt, bus.retired_count);
         chk($sformatf("rnd%0d_regwrite", c), {31'd0, bus.RegWrite}, {31'd0, wexp});
         chk($sformatf("rnd%0d_fwd_rs", c), {31'd0, bus.fwd_rs},
             {31'd0, wexp && (bus.id_rs == m_slot.dest)});
         chk($sformatf("rnd%0d_fwd_rt", c), {31'd0, bus.fwd_rt},
             {31'd0, wexp && (bus.id_rt == m_slot.dest)});
         chk($sformatf("rnd%0d_count", c), bus.retired_count, m_cnt);
         if (m_slot.known) begin
            chk($sformatf("rnd%0d_addr", c), {27'd0, bus.write_address}, {27'd0, m_slot.dest});
            chk($sformatf("rnd%0d_data", c), bus.write_data, m_data(m_slot));
         end
      end

      // Counter wrap: preload all-ones while stalled, then retire one instruction
      @(negedge clk);
      drive(0,0,1,1,2'd0,32'h22,32'h0,32'h0,5'd2,5'd0,5'd0);
      @(negedge clk);
      bus.stall = 1'b1;
      force dut.retired_q = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.retired_q;
      #1;
      chk("wrap_preload", bus.retired_count, 32'hFFFF_FFFF);
      chk("wrap_held_regwrite", {31'd0, bus.RegWrite}, 32'd1);
      @(negedge clk);
      drive(0,0,0,0,2'd0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0);
      @(posedge clk);
      #1;
      $display("wrap: count=%08h RegWrite=%0b", bus.retired_count, bus.RegWrite);
      chk("wrap_count", bus.retired_count, 32'd0);
      chk("wrap_regwrite", {31'd0, bus.RegWrite}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
